// File: rtl/moore_fsm_share_ctrl_pkg.sv
// Shared definitions for the round-robin controller around one shared Moore FSM:
// sequencer state encoding and a constant-friendly ceil-log2 helper.
package moore_fsm_share_ctrl_pkg;

  localparam logic [2:0] IDLE_ENC  = 3'd0;
  localparam logic [2:0] RSTF_ENC  = 3'd1;
  localparam logic [2:0] SHIFT_ENC = 3'd2;
  localparam logic [2:0] DRAIN_ENC = 3'd3;
  localparam logic [2:0] DONE_ENC  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = IDLE_ENC,
    RSTF  = RSTF_ENC,
    SHIFT = SHIFT_ENC,
    DRAIN = DRAIN_ENC,
    DONE  = DONE_ENC
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/moore_fsm_share_ctrl_if.sv
// Requester-side bus of the shared-FSM controller: requests and words in,
// grant/done/result/busy out.
interface moore_fsm_share_ctrl_if #(
  parameter int N   = 4,
  parameter int LEN = 8
);

  logic [N-1:0]     req;
  logic [N*LEN-1:0] data;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic [LEN-1:0]   result;
  logic             busy;

  modport master (output req, data, input gnt, done, result, busy);
  modport slave  (input req, data, output gnt, done, result, busy);

endinterface

// File: rtl/moore_fsm_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1
// with wrap-around; one-hot result, all zeros when nothing is requested.
module moore_fsm_share_ctrl_rr_arbiter
  import moore_fsm_share_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner
);

  logic found;

  // Offsets are scanned nearest-first; only constant indices are used so the
  // search unrolls into a flat priority network.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/moore_fsm_share_ctrl.sv
// Shares one Moore FSM between N requesters: grants round-robin, shifts the
// granted word into the FSM LSB first and collects its delayed response.
module moore_fsm_share_ctrl
  import moore_fsm_share_ctrl_pkg::*;
#(
  parameter int N   = 4,
  parameter int LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  moore_fsm_share_ctrl_if.slave   bus,
  output logic                    fsm_rst,
  output logic                    fsm_din,
  input  logic                    fsm_dout,
  input  logic [1:0]              fsm_state
);

  localparam int CW = clog2(LEN) + 1;
  localparam int PW = clog2(N);

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [LEN-1:0] word_q, word_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LEN-1:0] result_q, result_d;
  logic           fsm_rst_q, fsm_rst_d;
  logic           fsm_din_q, fsm_din_d;
  logic [N-1:0]   winner;
  logic           unused_fsm_state;

  assign unused_fsm_state = ^fsm_state;

  moore_fsm_share_ctrl_rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      word_q    <= '0;
      ptr_q     <= PW'(N - 1);
      cnt_q     <= '0;
      result_q  <= '0;
      fsm_rst_q <= 1'b0;
      fsm_din_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      word_q    <= word_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      fsm_rst_q <= fsm_rst_d;
      fsm_din_q <= fsm_din_d;
    end
  end

  // The FSM answers bit k one cycle after it is driven, so the capture index
  // trails the drive index by one and DRAIN picks up the last response.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    word_d   = word_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = winner;
          state_d = RSTF;
          for (int i = 0; i < N; i++) begin
            if (winner[i]) begin
              word_d = bus.data[i*LEN +: LEN];
              ptr_d  = PW'(i);
            end
          end
        end
      end
      RSTF: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        for (int i = 0; i < LEN - 1; i++) begin
          if (cnt_q == CW'(i + 1)) result_d[i] = fsm_dout;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LEN - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        result_d[LEN-1] = fsm_dout;
        state_d         = DONE;
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM-facing pins are flopped from the next state so they change cleanly
  // together with the sequencer.
  always_comb begin
    fsm_rst_d = (state_d == SHIFT) || (state_d == DRAIN);
    fsm_din_d = 1'b0;
    if (state_d == SHIFT) begin
      for (int i = 0; i < LEN; i++) begin
        if (cnt_d == CW'(i)) fsm_din_d = word_q[i];
      end
    end
  end

  assign fsm_rst    = fsm_rst_q;
  assign fsm_din    = fsm_din_q;
  assign bus.gnt    = gnt_q;
  assign bus.done   = (state_q == DONE) ? gnt_q : '0;
  assign bus.result = result_q;
  assign bus.busy   = (state_q != IDLE);

  gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));

endmodule

// File: tb/tb_moore_fsm_share_ctrl.sv
// Bench for moore_fsm_share_ctrl: a one-flop Moore FSM model echoes din, so each
// completed transaction must return the word latched at its grant.
module tb_moore_fsm_share_ctrl;

  localparam int N   = 4;
  localparam int LEN = 8;

  typedef struct {
    int             idx;
    logic [LEN-1:0] word;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       fsm_rst;
  logic       fsm_din;
  logic       m_q;
  logic [1:0] fsm_state;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t mon_exp;
  int   gnt_hold;
  int   done_at;

  moore_fsm_share_ctrl_if #(.N(N), .LEN(LEN)) bus ();

  moore_fsm_share_ctrl #(.N(N), .LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_rst   (fsm_rst),
    .fsm_din   (fsm_din),
    .fsm_dout  (m_q),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared FSM model: dout is din delayed by one flop, cleared while fsm_rst is low.
  always_ff @(posedge clk or negedge fsm_rst) begin
    if (!fsm_rst) m_q <= 1'b0;
    else          m_q <= fsm_din;
  end
  assign fsm_state = {1'b0, m_q};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic setWord(input int idx, input logic [LEN-1:0] word);
    bus.data[idx*LEN +: LEN] = word;
  endtask

  task automatic expectDone(input int idx, input logic [LEN-1:0] word);
    exp_t e;
    e.idx  = idx;
    e.word = word;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [N-1:0] req_mask);
    bus.req = req_mask;
  endtask

  task automatic waitGrants(input int n, input int budget);
    int         seen;
    logic [N-1:0] prev;
    seen = 0;
    prev = bus.gnt;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (bus.gnt != '0 && prev == '0) seen++;
      prev = bus.gnt;
    end
    checkOutput("grantCount", 32'(seen), 32'(n));
  endtask

  task automatic waitIdle(input int budget);
    int c;
    c = 0;
    while ((bus.busy || sb_q.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput("idleReached", 32'(bus.busy || sb_q.size() != 0), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Scoreboard monitor: pops one expectation per done pulse; also watches grant
  // one-hotness and that din stays low whenever the FSM is held in reset.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("gntOneHot", 32'($onehot0(bus.gnt)), 32'd1);
      checkOutput("doneOneHot", 32'($onehot0(bus.done)), 32'd1);
      if (!fsm_rst) checkOutput("dinQuiet", 32'(fsm_din), 32'd0);
      if (bus.done != '0) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpectedDone", 32'(bus.done), 32'd0);
        end else begin
          mon_exp = sb_q.pop_front();
          checkOutput("doneLine", 32'(bus.done), 32'(1) << mon_exp.idx);
          checkOutput("result", 32'(bus.result), 32'(mon_exp.word));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.data = '0;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstGnt",    32'(bus.gnt),    32'd0);
    checkOutput("rstDone",   32'(bus.done),   32'd0);
    checkOutput("rstResult", 32'(bus.result), 32'd0);
    checkOutput("rstBusy",   32'(bus.busy),   32'd0);
    checkOutput("rstFsmRst", 32'(fsm_rst),    32'd0);
    checkOutput("rstFsmDin", 32'(fsm_din),    32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single request; grant covers RSTF + LEN SHIFT + DRAIN + DONE = LEN+3 cycles,
    // with done on the last of them.
    $display("[TB] single request");
    setWord(0, 8'hA5);
    expectDone(0, 8'hA5);
    applyStimulus(4'b0001);
    waitGrants(1, 10);
    applyStimulus(4'b0000);
    gnt_hold = 0;
    done_at  = 0;
    while (bus.gnt == 4'b0001 && gnt_hold < 40) begin
      gnt_hold++;
      if (bus.done != '0) done_at = gnt_hold;
      @(negedge clk);
    end
    checkOutput("gntHold", 32'(gnt_hold), 32'(LEN + 3));
    checkOutput("doneAt",  32'(done_at),  32'(LEN + 3));
    waitIdle(40);

    // All four requesting after reset (ptr = N-1): order 0,1,2,3,0.
    $display("[TB] all requesters");
    pulseReset();
    setWord(0, 8'h11);
    setWord(1, 8'h22);
    setWord(2, 8'h33);
    setWord(3, 8'h44);
    expectDone(0, 8'h11);
    expectDone(1, 8'h22);
    expectDone(2, 8'h33);
    expectDone(3, 8'h44);
    expectDone(0, 8'h11);
    applyStimulus(4'b1111);
    waitGrants(5, 100);
    applyStimulus(4'b0000);
    waitIdle(40);

    // Requesters 1 and 3 alternate, ptr starts at 0.
    $display("[TB] alternating pair");
    expectDone(1, 8'h22);
    expectDone(3, 8'h44);
    expectDone(1, 8'h22);
    expectDone(3, 8'h44);
    applyStimulus(4'b1010);
    waitGrants(4, 80);
    applyStimulus(4'b0000);
    waitIdle(40);

    // Request dropped and word changed mid-transaction: latched word still returned.
    $display("[TB] drop request mid-transaction");
    setWord(2, 8'h5C);
    expectDone(2, 8'h5C);
    applyStimulus(4'b0100);
    waitGrants(1, 10);
    repeat (2) @(negedge clk);
    applyStimulus(4'b0000);
    repeat (2) @(negedge clk);
    setWord(2, 8'hFF);
    waitIdle(40);

    // Reset while shifting bit 3: outputs clear at once and no done follows.
    $display("[TB] reset mid-shift");
    setWord(0, 8'hA5);
    applyStimulus(4'b0001);
    waitGrants(1, 10);
    repeat (4) @(negedge clk);
    applyStimulus(4'b0000);
    rst = 1'b0;
    #1;
    checkOutput("midRstGnt",    32'(bus.gnt),    32'd0);
    checkOutput("midRstBusy",   32'(bus.busy),   32'd0);
    checkOutput("midRstFsmRst", 32'(fsm_rst),    32'd0);
    checkOutput("midRstResult", 32'(bus.result), 32'd0);
    checkOutput("midRstDone",   32'(bus.done),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("postRstIdle", 32'(bus.busy), 32'd0);
    setWord(1, 8'h3C);
    expectDone(1, 8'h3C);
    applyStimulus(4'b0010);
    waitGrants(1, 10);
    applyStimulus(4'b0000);
    waitIdle(40);

    // Extreme words on requester 1.
    $display("[TB] all-zero and all-one words");
    setWord(1, 8'h00);
    expectDone(1, 8'h00);
    applyStimulus(4'b0010);
    waitGrants(1, 10);
    applyStimulus(4'b0000);
    waitIdle(40);
    setWord(1, 8'hFF);
    expectDone(1, 8'hFF);
    applyStimulus(4'b0010);
    waitGrants(1, 10);
    applyStimulus(4'b0000);
    waitIdle(40);

    repeat (2) @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
